// File: rtl/ring_arbiter_if.sv
// ============================================================================
// ring_arbiter_if : request/grant bundle between requesting engines and the arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

interface ring_arbiter_if #(
   parameter int N = 4
);
   localparam int IDW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]   req;
   logic [N-1:0]   gnt;
   logic           gnt_valid;
   logic [IDW-1:0] gnt_id;
   logic [N-1:0]   ptr;

   modport master (
      output req,
      input  gnt,
      input  gnt_valid,
      input  gnt_id,
      input  ptr
   );

   modport slave (
      input  req,
      output gnt,
      output gnt_valid,
      output gnt_id,
      output ptr
   );
endinterface

`default_nettype wire

// File: rtl/ring_arbiter.sv
// ============================================================================
// ring_arbiter : round-robin arbiter with one-hot rotating priority and hold limit
// Revision 1.0
// ============================================================================
`default_nettype none

module ring_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8
) (
   input  wire            clk,
   input  wire            reset_n,
   ring_arbiter_if.slave  bus
);
   localparam int IDW = (N > 1) ? $clog2(N) : 1;
   localparam int HW  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

   localparam logic [HW-1:0] C_MAX_HOLD  = HW'(MAX_HOLD);
   localparam logic [HW-1:0] C_HOLD_INIT = HW'((MAX_HOLD != 0) ? 1 : 0);
   localparam logic [N-1:0]  C_PTR_RST   = {1'b1, {(N-1){1'b0}}};
   localparam logic [N-1:0]  C_ONE       = {{(N-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t         state_q,     state_d;
   logic [N-1:0]   gnt_q,       gnt_d;
   logic           gnt_valid_q, gnt_valid_d;
   logic [IDW-1:0] gnt_id_q,    gnt_id_d;
   logic [N-1:0]   ptr_q,       ptr_d;
   logic [HW-1:0]  hold_cnt_q,  hold_cnt_d;

   logic [IDW-1:0] w_ptr_idx;
   logic [IDW-1:0] w_pick_id;
   logic           w_pick_found;
   logic           w_release;

   // Scan from the pointer position downward with wrap; first set request wins.
   always_comb begin
      int idx;
      logic [IDW-1:0] idx_v;
      idx          = 0;
      idx_v        = '0;
      w_ptr_idx    = '0;
      w_pick_id    = '0;
      w_pick_found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (ptr_q[i]) w_ptr_idx = IDW'(i);
      end
      for (int k = 0; k < N; k++) begin
         idx   = (int'(w_ptr_idx) + N - k) % N;
         idx_v = IDW'(idx);
         if (!w_pick_found && bus.req[idx_v]) begin
            w_pick_found = 1'b1;
            w_pick_id    = idx_v;
         end
      end
   end

   always_comb begin
      w_release = 1'b0;
      if (!bus.req[gnt_id_q]) begin
         w_release = 1'b1;
      end else if ((MAX_HOLD != 0) && (hold_cnt_q == C_MAX_HOLD) &&
                   (|(bus.req & ~gnt_q))) begin
         w_release = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gnt_valid_d = gnt_valid_q;
      gnt_id_d    = gnt_id_q;
      ptr_d       = ptr_q;
      hold_cnt_d  = hold_cnt_q;
      case (state_q)
         IDLE: begin
            if (w_pick_found) begin
               gnt_d       = C_ONE << w_pick_id;
               gnt_valid_d = 1'b1;
               gnt_id_d    = w_pick_id;
               hold_cnt_d  = C_HOLD_INIT;
               state_d     = GRANT;
            end
         end
         GRANT: begin
            if (w_release) begin
               gnt_d       = '0;
               gnt_valid_d = 1'b0;
               gnt_id_d    = '0;
               hold_cnt_d  = '0;
               // Owner drops to lowest priority: pointer moves one below it.
               ptr_d       = {gnt_q[0], gnt_q[N-1:1]};
               state_d     = IDLE;
            end else if (hold_cnt_q != C_MAX_HOLD) begin
               hold_cnt_d  = hold_cnt_q + HW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         gnt_valid_q <= 1'b0;
         gnt_id_q    <= '0;
         ptr_q       <= C_PTR_RST;
         hold_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_valid_q <= gnt_valid_d;
         gnt_id_q    <= gnt_id_d;
         ptr_q       <= ptr_d;
         hold_cnt_q  <= hold_cnt_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_valid = gnt_valid_q;
   assign bus.gnt_id    = gnt_id_q;
   assign bus.ptr       = ptr_q;

endmodule

`default_nettype wire
